// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register word indices,
// per-source mode encodings and the field layout of the VEC register.
package int_ctrl_pkg;

    // Register word indices inside the controller's window
    localparam int REG_PEND = 0;
    localparam int REG_MASK = 1;
    localparam int REG_MODE = 2;
    localparam int REG_VEC  = 3;

    // MODE register bit encoding
    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

    // VEC register layout
    localparam int VEC_INT_BIT = 31;
    localparam int VEC_ID_LSB  = 0;
    localparam int VEC_ID_W    = 5;

endpackage

// File: rtl/int_ctrl_irq_sync.sv
// Multi-bit synchroniser with edge history for raw interrupt inputs.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   async_i - raw, possibly asynchronous request lines
//   s_o     - synchronised request level
//   rise_o  - one-cycle rising-edge indication of s_o
module irq_sync
    import int_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] s_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
            hist_q <= '0;
        end else begin
            stage_q[0] <= async_i;
            for (int k = 1; k < STAGES; k++) stage_q[k] <= stage_q[k-1];
            hist_q <= stage_q[STAGES-1];
        end
    end

    assign s_o    = stage_q[STAGES-1];
    assign rise_o = s_o & ~hist_q;

endmodule

// File: rtl/int_ctrl.sv
// Maskable, fixed-priority interrupt controller feeding the CPU INT input.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   irq_in    - raw interrupt requests (one per source)
//   addr, wdata, we - register window write/read port (word addressed)
//   rdata     - registered read data for the previous cycle's addr
//   int_o     - interrupt request to the CPU
//   int_id    - index of highest-priority active source (0 = highest)
//   int_ack   - one-cycle pulse: CPU has taken the current interrupt
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [31:0]        wdata,
    input  logic               we,
    output logic [31:0]        rdata,
    output logic               int_o,
    output logic [4:0]         int_id,
    input  logic               int_ack
);

    logic [NUM_SRC-1:0] sync_s;
    logic [NUM_SRC-1:0] sync_rise;

    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               int_o_q, int_o_d;
    logic [4:0]         int_id_q, int_id_d;

    logic [NUM_SRC-1:0] w1c_clr;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] edge_next;
    logic [NUM_SRC-1:0] active;

    irq_sync #(
        .WIDTH  (NUM_SRC),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (irq_in),
        .s_o     (sync_s),
        .rise_o  (sync_rise)
    );

    function automatic logic [31:0] zext(input logic [NUM_SRC-1:0] v);
        zext = '0;
        zext[NUM_SRC-1:0] = v;
    endfunction

    // Scan from the top so the lowest set index is the one left standing.
    function automatic logic [4:0] prio_enc(input logic [NUM_SRC-1:0] a);
        prio_enc = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (a[i]) prio_enc = 5'(i);
        end
    endfunction

    always_comb begin
        w1c_clr = '0;
        if (we && (addr == ADDR_W'(REG_PEND))) w1c_clr = wdata[NUM_SRC-1:0];

        // Ack only counts when an interrupt is actually being presented.
        ack_clr = '0;
        if (int_ack && int_o_q) ack_clr = NUM_SRC'(1) << int_id_q;

        // Set wins over clear for edge sources; level sources just track s.
        edge_next = (pend_q & ~(w1c_clr | ack_clr)) | sync_rise;
        pend_d    = (mode_q & edge_next) | (~mode_q & sync_s);

        mask_d = mask_q;
        if (we && (addr == ADDR_W'(REG_MASK))) mask_d = wdata[NUM_SRC-1:0];
        mode_d = mode_q;
        if (we && (addr == ADDR_W'(REG_MODE))) mode_d = wdata[NUM_SRC-1:0];

        active   = pend_q & mask_q;
        int_o_d  = |active;
        int_id_d = prio_enc(active);

        rdata_d = '0;
        if (addr == ADDR_W'(REG_PEND)) begin
            rdata_d = zext(pend_q);
        end else if (addr == ADDR_W'(REG_MASK)) begin
            rdata_d = zext(mask_q);
        end else if (addr == ADDR_W'(REG_MODE)) begin
            rdata_d = zext(mode_q);
        end else if (addr == ADDR_W'(REG_VEC)) begin
            rdata_d[VEC_INT_BIT]                = int_o_q;
            rdata_d[VEC_ID_LSB +: VEC_ID_W]     = int_id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            mask_q   <= '0;
            mode_q   <= {NUM_SRC{MODE_LEVEL}};
            rdata_q  <= '0;
            int_o_q  <= 1'b0;
            int_id_q <= '0;
        end else begin
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            rdata_q  <= rdata_d;
            int_o_q  <= int_o_d;
            int_id_q <= int_id_d;
        end
    end

    assign rdata  = rdata_q;
    assign int_o  = int_o_q;
    assign int_id = int_id_q;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        int_o;
    logic [4:0]  int_id;
    logic        int_ack;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    vec_t tbl [6];
    sb_t  sb_q [$];

    int_ctrl #(
        .NUM_SRC     (8),
        .SYNC_STAGES (2),
        .ADDR_W      (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_in  (irq_in),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .rdata   (rdata),
        .int_o   (int_o),
        .int_id  (int_id),
        .int_ack (int_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    // Read through the scoreboard: expectation queued at drive time,
    // compared when the registered rdata appears.
    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        sb_t e;
        addr = a;
        we   = 1'b0;
        sb_q.push_back('{exp, name});
        tick();
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.name, rdata, e.exp);
        end
    endtask

    task automatic ack_pulse();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'd1, 32'hFFFF_FF3C, 2'd1, 32'h0000_003C, "mask_rw_upper_ignored"};
        tbl[1] = '{2'd2, 32'h0000_01A5, 2'd2, 32'h0000_00A5, "mode_rw_upper_ignored"};
        tbl[2] = '{2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000, "vec_write_ignored"};
        tbl[3] = '{2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0000_0000, "pend_w1c_idle"};
        tbl[4] = '{2'd1, 32'h0000_0000, 2'd1, 32'h0000_0000, "mask_clear"};
        tbl[5] = '{2'd2, 32'h0000_0000, 2'd2, 32'h0000_0000, "mode_clear"};

        rst = 1'b1; irq_in = 8'hFF; addr = 2'd0; wdata = '0; we = 1'b0; int_ack = 1'b0;

        // Reset with all inputs high
        tick();
        check("rst_int_o", {31'd0, int_o}, 32'd0);
        check("rst_int_id", {27'd0, int_id}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        ticks(3);
        check("pend_before_visible", rdata, 32'd0);
        tick();
        check("pend_level_ff", rdata, 32'h0000_00FF);
        check("masked_level_int_o", {31'd0, int_o}, 32'd0);
        irq_in = 8'h00;
        ticks(5);

        // Register table
        for (int i = 0; i < 6; i++) begin
            wr(tbl[i].waddr, tbl[i].wdata);
            rd(tbl[i].raddr, tbl[i].exp, tbl[i].name);
        end

        // Same-cycle write is not yet visible in rdata
        addr = 2'd1; wdata = 32'h55; we = 1'b1;
        sb_q.push_back('{32'h0, "same_cycle_write_old"});
        tick();
        we = 1'b0;
        begin
            sb_t e;
            e = sb_q.pop_front();
            check(e.name, rdata, e.exp);
        end
        rd(2'd1, 32'h55, "same_cycle_write_new");
        wr(2'd1, 32'h0);

        // Edge source latency and ack
        wr(2'd2, 32'h08);
        wr(2'd1, 32'h08);
        irq_in = 8'h08;
        tick();
        irq_in = 8'h00;
        ticks(2);
        check("edge_lat_minus1", {31'd0, int_o}, 32'd0);
        tick();
        check("edge_lat_int_o", {31'd0, int_o}, 32'd1);
        check("edge_lat_id", {27'd0, int_id}, 32'd3);
        ack_pulse();
        check("ack_int_o_1cyc", {31'd0, int_o}, 32'd1);
        tick();
        check("ack_int_o_2cyc", {31'd0, int_o}, 32'd0);
        rd(2'd0, 32'h0, "ack_pend_clear");

        // Priority between two simultaneous edges
        wr(2'd2, 32'hFF);
        wr(2'd1, 32'hFF);
        irq_in = 8'h24;
        ticks(4);
        check("prio_int_o", {31'd0, int_o}, 32'd1);
        check("prio_id2", {27'd0, int_id}, 32'd2);
        ack_pulse();
        tick();
        check("prio_after_ack_id5", {27'd0, int_id}, 32'd5);
        check("prio_after_ack_int_o", {31'd0, int_o}, 32'd1);
        ack_pulse();
        tick();
        check("prio_all_acked", {31'd0, int_o}, 32'd0);
        irq_in = 8'h00;
        ticks(3);

        // W1C in the same cycle as a new edge: set wins
        irq_in = 8'h02;
        ticks(2);
        addr = 2'd0; wdata = 32'h2; we = 1'b1;
        tick();
        we = 1'b0;
        rd(2'd0, 32'h02, "w1c_vs_edge");
        wr(2'd0, 32'h2);
        rd(2'd0, 32'h00, "w1c_clear");
        irq_in = 8'h00;
        ticks(3);

        // Level source ignores ack and W1C
        wr(2'd2, 32'h00);
        wr(2'd1, 32'h01);
        irq_in = 8'h01;
        ticks(4);
        check("level_int_o", {31'd0, int_o}, 32'd1);
        check("level_id0", {27'd0, int_id}, 32'd0);
        ack_pulse();
        wr(2'd0, 32'h1);
        ticks(2);
        check("level_ack_w1c_ignored", {31'd0, int_o}, 32'd1);
        irq_in = 8'h00;
        ticks(3);
        check("level_drop_minus1", {31'd0, int_o}, 32'd1);
        tick();
        check("level_drop", {31'd0, int_o}, 32'd0);

        // Masked edge capture, then unmask
        wr(2'd1, 32'h00);
        wr(2'd2, 32'h80);
        irq_in = 8'h80;
        tick();
        irq_in = 8'h00;
        ticks(4);
        check("masked_int_o", {31'd0, int_o}, 32'd0);
        rd(2'd0, 32'h80, "masked_pend");
        wr(2'd1, 32'h80);
        tick();
        check("unmask_int_o", {31'd0, int_o}, 32'd1);
        check("unmask_id7", {27'd0, int_id}, 32'd7);
        rd(2'd3, 32'h8000_0007, "vec_read");

        // Reset mid-operation overrides a write and an ack
        rst = 1'b1; addr = 2'd1; wdata = 32'hFF; we = 1'b1; int_ack = 1'b1;
        tick();
        rst = 1'b0; we = 1'b0; int_ack = 1'b0;
        check("midrst_int_o", {31'd0, int_o}, 32'd0);
        rd(2'd1, 32'h0, "midrst_mask");
        rd(2'd0, 32'h0, "midrst_pend");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
